// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl -- nibble-serial unsigned magnitude comparator controller.
//
// Accepts a WIDTH-bit operand pair over a valid/ready handshake. One shared
// comp_4bit instance is stepped across the nibbles, most significant nibble
// first. The walk stops at the first unequal nibble. The result is registered
// as E/G/L plus the number of nibbles examined, and is held until the consumer
// takes it.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   A, B                 operands, sampled on in_valid & in_ready
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   E, G, L              A==B, A>B, A<B (unsigned), one-hot while out_valid
//   nib_cnt              nibbles examined for this result, 1..NIB
//   busy                 high while the compare is in progress (RUN)

module comp_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       e,
  output logic       g,
  output logic       l
);
  always_comb begin
    e = (a == b);
    g = (a > b);
    l = (a < b);
  end
endmodule

module comp_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                A,
  input  logic [WIDTH-1:0]                B,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            E,
  output logic                            G,
  output logic                            L,
  output logic [$clog2(WIDTH/4+1)-1:0]    nib_cnt,
  output logic                            busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("comp_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             e_r;
  logic             g_r;
  logic             l_r;
  logic [CW-1:0]    nib_cnt_r;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic             nib_e;
  logic             nib_g;
  logic             nib_l;

  // Select the current nibble by shifting it down to bit 0.
  assign a_nib = 4'(a_r >> {idx, 2'b00});
  assign b_nib = 4'(b_r >> {idx, 2'b00});

  comp_4bit u_comp (
    .a (a_nib),
    .b (b_nib),
    .e (nib_e),
    .g (nib_g),
    .l (nib_l)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      cnt       <= '0;
      e_r       <= 1'b0;
      g_r       <= 1'b0;
      l_r       <= 1'b0;
      nib_cnt_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= A;
            b_r   <= B;
            idx   <= IW'(NIB - 1);
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!nib_e) begin
            e_r       <= 1'b0;
            g_r       <= nib_g;
            l_r       <= nib_l;
            nib_cnt_r <= cnt + CW'(1);
            state     <= DONE;
          end else if (idx == '0) begin
            e_r       <= 1'b1;
            g_r       <= 1'b0;
            l_r       <= 1'b0;
            nib_cnt_r <= CW'(NIB);
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign E         = e_r;
  assign G         = g_r;
  assign L         = l_r;
  assign nib_cnt   = nib_cnt_r;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
module tb_comp_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int CW    = $clog2(NIB + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic             E, G, L;
  logic [CW-1:0]    nib_cnt;
  logic             busy;

  int unsigned total  = 0;
  int unsigned passed = 0;

  comp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .E         (E),
    .G         (G),
    .L         (L),
    .nib_cnt   (nib_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: unsigned compare; nibble count derived from the position of the
  // highest differing bit (all nibbles when operands are equal).
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic e, output logic g, output logic l,
                                output int cnt);
    logic [WIDTH-1:0] diff;
    int p;
    e = (a == b);
    g = (a > b);
    l = (a < b);
    diff = a ^ b;
    p = -1;
    for (int i = 0; i < WIDTH; i++) if (diff[i]) p = i;
    cnt = (p < 0) ? NIB : NIB - p / 4;
  endfunction

  // One full transaction: accept, optional disturbance in RUN, latency check,
  // result hold with out_ready low, then release.
  task automatic do_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int hold, input bit disturb);
    logic ee, eg, el;
    int ec, lat, w;
    model(a, b, ee, eg, el, ec);
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'(ec > 0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (disturb && lat == 0) begin
        A = $urandom; B = $urandom; in_valid = 1'b1;
        check("in_ready_in_run", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'(ec));
    for (int h = 0; h <= hold; h++) begin
      check("out_valid_hold", 32'(out_valid), 32'd1);
      check("E", 32'(E), 32'(ee));
      check("G", 32'(G), 32'(eg));
      check("L", 32'(L), 32'(el));
      check("nib_cnt", 32'(nib_cnt), 32'(ec));
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("E_retained", 32'(E), 32'(ee));
    check("nib_cnt_retained", 32'(nib_cnt), 32'(ec));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, mask;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_EGL", {29'd0, E, G, L}, 32'd0);
    check("rst_nib_cnt", 32'(nib_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready high while idle must have no effect
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("early_out_ready", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    do_compare(16'h1234, 16'h1234, 0, 1'b0);
    do_compare(16'h8000, 16'h7FFF, 0, 1'b0);
    do_compare(16'h1230, 16'h1231, 0, 1'b0);
    do_compare(16'h0F00, 16'h0E00, 0, 1'b0);
    do_compare(16'h5A5A, 16'h5A5B, 5, 1'b0);
    do_compare(16'h1234, 16'h1234, 1, 1'b1);
    do_compare(16'h0000, 16'hFFFF, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = WIDTH'($urandom);
        default: begin
          mask = WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1);
          rb = ra ^ mask;
        end
      endcase
      do_compare(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during the second RUN cycle discards the pending compare.
    A = 16'h1234; B = 16'h1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_EGL", {29'd0, E, G, L}, 32'd0);
    check("midrun_rst_nib_cnt", 32'(nib_cnt), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("out_valid_after_reset", 32'(out_valid), 32'd0);
    do_compare(16'hABCD, 16'hABCC, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
